// File: rtl/multicycle_control_fsm_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm_if
// Bundles the signals between the multicycle core's main control FSM and its
// datapath.
//   master : the control FSM. It receives the instruction fields and the
//            datapath/memory status, and drives the mux selects, the write
//            enables, the ALU operation and the debug state.
//   slave  : the datapath/memory side (the mirror image of master).
// Status into the FSM : opcode, funct3, funct7_5, zero, mem_ready
// Controls out of it  : mem_read, mem_write, adr_src, ir_write, pc_write,
//                       reg_write, alu_src_a, alu_src_b, result_src,
//                       alu_operation, illegal_instr, state
// ---------------------------------------------------------------------------
interface multicycle_control_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;

    logic       mem_read;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [3:0] alu_operation;
    logic       illegal_instr;
    logic [3:0] state;

    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_operation,
               illegal_instr, state
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_operation,
               illegal_instr, state
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
// Main control FSM of the multicycle RV32I-subset core (lw, sw, add/sub/and/or,
// addi/ori/andi, beq). It sequences fetch, decode, execute, memory and
// writeback. The outputs are Moore decodes of the state, except that
// mem_ready qualifies ir_write/pc_write in FETCH and zero qualifies pc_write
// in BEQ.
// Ports:
//   clk     : single clock, rising edge
//   reset_n : synchronous, active-low reset. While it is low, every output is
//             forced to 0 combinationally.
//   bus     : multicycle_control_fsm_if.master (instruction fields and status
//             in; mux selects, enables, ALU op and debug state out)
// Parameter:
//   HALT_ON_ILLEGAL : 1 = ILLEGAL is held until reset, 0 = ILLEGAL lasts one
//                     cycle and then the FSM returns to FETCH.
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    multicycle_control_fsm_if.master      bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    state_t state_reg;
    state_t state_next;

    // Instruction decode. The IR is stable from the cycle after its write,
    // so these are valid from DECODE onwards.
    logic       r_legal;
    logic       i_legal;
    logic [3:0] r_alu_op;
    logic [3:0] i_alu_op;

    always_comb begin
        r_legal  = 1'b0;
        r_alu_op = ALU_ADD;
        case ({bus.funct3, bus.funct7_5})
            4'b0000: begin r_legal = 1'b1; r_alu_op = ALU_ADD; end
            4'b0001: begin r_legal = 1'b1; r_alu_op = ALU_SUB; end
            4'b1100: begin r_legal = 1'b1; r_alu_op = ALU_OR;  end
            4'b1110: begin r_legal = 1'b1; r_alu_op = ALU_AND; end
            default: begin r_legal = 1'b0; r_alu_op = ALU_ADD; end
        endcase
    end

    // For I-type, IR[30] is immediate data, so only funct3 selects the op.
    always_comb begin
        i_legal  = 1'b0;
        i_alu_op = ALU_ADD;
        case (bus.funct3)
            3'b000:  begin i_legal = 1'b1; i_alu_op = ALU_ADD; end
            3'b110:  begin i_legal = 1'b1; i_alu_op = ALU_OR;  end
            3'b111:  begin i_legal = 1'b1; i_alu_op = ALU_AND; end
            default: begin i_legal = 1'b0; i_alu_op = ALU_ADD; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next         = S_FETCH;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.adr_src        = 1'b0;
        bus.ir_write       = 1'b0;
        bus.pc_write       = 1'b0;
        bus.reg_write      = 1'b0;
        bus.alu_src_a      = 2'b00;
        bus.alu_src_b      = 2'b00;
        bus.result_src     = 2'b00;
        bus.alu_operation  = ALU_AND;
        bus.illegal_instr  = 1'b0;
        bus.state          = state_reg;

        case (state_reg)
            S_FETCH: begin
                // Read the instruction at PC and compute PC+4 on the ALU,
                // routed straight to the result bus; both the IR and the PC
                // load only in the cycle the memory completes.
                bus.mem_read      = 1'b1;
                bus.alu_src_b     = 2'b10;
                bus.alu_operation = ALU_ADD;
                bus.result_src    = 2'b10;
                bus.ir_write      = bus.mem_ready;
                bus.pc_write      = bus.mem_ready;
                state_next        = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // OldPC + ImmExt: branch target lands in ALUOut for BEQ.
                bus.alu_src_a     = 2'b01;
                bus.alu_src_b     = 2'b01;
                bus.alu_operation = ALU_ADD;
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = r_legal ? S_EXECUTER : S_ILLEGAL;
                    OP_ITYPE:     state_next = i_legal ? S_EXECUTEI : S_ILLEGAL;
                    OP_BRANCH:    state_next = (bus.funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a     = 2'b10;
                bus.alu_src_b     = 2'b01;
                bus.alu_operation = ALU_ADD;
                state_next        = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.mem_read = 1'b1;
                bus.adr_src  = 1'b1;
                state_next   = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                bus.result_src = 2'b01;
                bus.reg_write  = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.mem_write = 1'b1;
                bus.adr_src   = 1'b1;
                state_next    = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                bus.alu_src_a     = 2'b10;
                bus.alu_src_b     = 2'b00;
                bus.alu_operation = r_alu_op;
                state_next        = S_ALUWB;
            end
            S_EXECUTEI: begin
                bus.alu_src_a     = 2'b10;
                bus.alu_src_b     = 2'b01;
                bus.alu_operation = i_alu_op;
                state_next        = S_ALUWB;
            end
            S_ALUWB: begin
                bus.result_src = 2'b00;
                bus.reg_write  = 1'b1;
                state_next     = S_FETCH;
            end
            S_BEQ: begin
                // ALUOut still holds the target from DECODE; take it when
                // rs1 - rs2 is zero.
                bus.alu_src_a     = 2'b10;
                bus.alu_src_b     = 2'b00;
                bus.alu_operation = ALU_SUB;
                bus.result_src    = 2'b00;
                bus.pc_write      = bus.zero;
                state_next        = S_FETCH;
            end
            S_ILLEGAL: begin
                bus.illegal_instr = 1'b1;
                state_next        = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Reset overrides everything, so an abandoned instruction cannot
        // complete an access in the reset cycle.
        if (!reset_n) begin
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.adr_src       = 1'b0;
            bus.ir_write      = 1'b0;
            bus.pc_write      = 1'b0;
            bus.reg_write     = 1'b0;
            bus.alu_src_a     = 2'b00;
            bus.alu_src_b     = 2'b00;
            bus.result_src    = 2'b00;
            bus.alu_operation = 4'b0000;
            bus.illegal_instr = 1'b0;
            bus.state         = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Drives two copies of the control FSM (HALT_ON_ILLEGAL = 1 and 0) with the
// same directed inputs. A table of per-cycle {inputs, expected state, expected
// control word} records covers the legal instruction flows; hand-written
// sequences cover illegal encodings and reset in the middle of a store.
// Inputs change after the falling edge; outputs are checked 1 ns later,
// well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    logic clk;
    logic reset_n;

    multicycle_control_fsm_if ifh ();
    multicycle_control_fsm_if ifn ();

    multicycle_control_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifh.master)
    );

    multicycle_control_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut_n (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifn.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {mem_read, mem_write, adr_src, ir_write, pc_write,
    //                reg_write, alu_src_a, alu_src_b, result_src,
    //                alu_operation, illegal_instr}
    logic [16:0] ctl_h;
    logic [16:0] ctl_n;
    assign ctl_h = {ifh.mem_read, ifh.mem_write, ifh.adr_src, ifh.ir_write,
                    ifh.pc_write, ifh.reg_write, ifh.alu_src_a, ifh.alu_src_b,
                    ifh.result_src, ifh.alu_operation, ifh.illegal_instr};
    assign ctl_n = {ifn.mem_read, ifn.mem_write, ifn.adr_src, ifn.ir_write,
                    ifn.pc_write, ifn.reg_write, ifn.alu_src_a, ifn.alu_src_b,
                    ifn.result_src, ifn.alu_operation, ifn.illegal_instr};

    function automatic logic [16:0] cv(input logic mr, input logic mw,
                                       input logic as_, input logic irw,
                                       input logic pcw, input logic rw,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] rs, input logic [3:0] op,
                                       input logic ill);
        return {mr, mw, as_, irw, pcw, rw, sa, sb, rs, op, ill};
    endfunction

    typedef struct {
        logic        rst_n;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f75;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ctl;
    } vec_t;

    vec_t tbl[$];

    int checks;
    int errors;

    logic [16:0] fet1, fet0, dec, madr, mrd, mwb, mwr;
    logic [16:0] exr_add, exr_sub, exr_and, exi_or, exi_add, awb;
    logic [16:0] beq1, beq0, ill;

    task automatic row(input logic rst_n, input logic [6:0] opc,
                       input logic [2:0] f3, input logic f75, input logic zero,
                       input logic rdy, input logic [3:0] st,
                       input logic [16:0] ctl);
        vec_t v;
        v.rst_n = rst_n; v.opc = opc; v.f3 = f3; v.f75 = f75;
        v.zero = zero; v.rdy = rdy; v.st = st; v.ctl = ctl;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst_n, input logic [6:0] opc,
                         input logic [2:0] f3, input logic f75,
                         input logic zero, input logic rdy);
        reset_n       = rst_n;
        ifh.opcode    = opc;  ifn.opcode    = opc;
        ifh.funct3    = f3;   ifn.funct3    = f3;
        ifh.funct7_5  = f75;  ifn.funct7_5  = f75;
        ifh.zero      = zero; ifn.zero      = zero;
        ifh.mem_ready = rdy;  ifn.mem_ready = rdy;
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] st_a,
                       input logic [3:0] st_e, input logic [16:0] c_a,
                       input logic [16:0] c_e);
        checks++;
        if (st_a !== st_e || c_a !== c_e) begin
            errors++;
            $display("FAIL %s: state %0d ctl %05h, required state %0d ctl %05h",
                     name, st_a, c_a, st_e, c_e);
        end
    endtask

    task automatic chk_both(input string name, input logic [3:0] st_e,
                            input logic [16:0] c_e);
        chk({name, "/halt1"}, ifh.state, st_e, ctl_h, c_e);
        chk({name, "/halt0"}, ifn.state, st_e, ctl_n, c_e);
    endtask

    logic [6:0] bad_opc [5];
    logic [2:0] bad_f3  [5];
    logic       bad_f75 [5];

    initial begin
        checks = 0;
        errors = 0;

        fet1    = cv(1,0,0,1,1,0, 2'b00, 2'b10, 2'b10, 4'b0010, 0);
        fet0    = cv(1,0,0,0,0,0, 2'b00, 2'b10, 2'b10, 4'b0010, 0);
        dec     = cv(0,0,0,0,0,0, 2'b01, 2'b01, 2'b00, 4'b0010, 0);
        madr    = cv(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 4'b0010, 0);
        mrd     = cv(1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        mwb     = cv(0,0,0,0,0,1, 2'b00, 2'b00, 2'b01, 4'b0000, 0);
        mwr     = cv(0,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        exr_add = cv(0,0,0,0,0,0, 2'b10, 2'b00, 2'b00, 4'b0010, 0);
        exr_sub = cv(0,0,0,0,0,0, 2'b10, 2'b00, 2'b00, 4'b0110, 0);
        exr_and = cv(0,0,0,0,0,0, 2'b10, 2'b00, 2'b00, 4'b0000, 0);
        exi_or  = cv(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 4'b0001, 0);
        exi_add = cv(0,0,0,0,0,0, 2'b10, 2'b01, 2'b00, 4'b0010, 0);
        awb     = cv(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 4'b0000, 0);
        beq1    = cv(0,0,0,0,1,0, 2'b10, 2'b00, 2'b00, 4'b0110, 0);
        beq0    = cv(0,0,0,0,0,0, 2'b10, 2'b00, 2'b00, 4'b0110, 0);
        ill     = cv(0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 4'b0000, 1);

        // Reset held three cycles: everything 0.
        for (int i = 0; i < 3; i++) row(0, RT, 3'b000, 0, 0, 1, 4'd0, 17'd0);
        // add
        row(1, RT, 3'b000, 0, 0, 1, 4'd0, fet1);
        row(1, RT, 3'b000, 0, 0, 1, 4'd1, dec);
        row(1, RT, 3'b000, 0, 0, 1, 4'd6, exr_add);
        row(1, RT, 3'b000, 0, 0, 1, 4'd8, awb);
        // sub
        row(1, RT, 3'b000, 1, 0, 1, 4'd0, fet1);
        row(1, RT, 3'b000, 1, 0, 1, 4'd1, dec);
        row(1, RT, 3'b000, 1, 0, 1, 4'd6, exr_sub);
        row(1, RT, 3'b000, 1, 0, 1, 4'd8, awb);
        // and
        row(1, RT, 3'b111, 0, 0, 1, 4'd0, fet1);
        row(1, RT, 3'b111, 0, 0, 1, 4'd1, dec);
        row(1, RT, 3'b111, 0, 0, 1, 4'd6, exr_and);
        row(1, RT, 3'b111, 0, 0, 1, 4'd8, awb);
        // ori
        row(1, IT, 3'b110, 0, 0, 1, 4'd0, fet1);
        row(1, IT, 3'b110, 0, 0, 1, 4'd1, dec);
        row(1, IT, 3'b110, 0, 0, 1, 4'd7, exi_or);
        row(1, IT, 3'b110, 0, 0, 1, 4'd8, awb);
        // addi (immediate bit 30 set must not turn it into a subtract)
        row(1, IT, 3'b000, 1, 0, 1, 4'd0, fet1);
        row(1, IT, 3'b000, 1, 0, 1, 4'd1, dec);
        row(1, IT, 3'b000, 1, 0, 1, 4'd7, exi_add);
        row(1, IT, 3'b000, 1, 0, 1, 4'd8, awb);
        // lw: one fetch wait cycle, two MEMREAD wait cycles
        row(1, LW, 3'b010, 0, 0, 0, 4'd0, fet0);
        row(1, LW, 3'b010, 0, 0, 1, 4'd0, fet1);
        row(1, LW, 3'b010, 0, 0, 1, 4'd1, dec);
        row(1, LW, 3'b010, 0, 0, 1, 4'd2, madr);
        row(1, LW, 3'b010, 0, 0, 0, 4'd3, mrd);
        row(1, LW, 3'b010, 0, 0, 0, 4'd3, mrd);
        row(1, LW, 3'b010, 0, 0, 1, 4'd3, mrd);
        row(1, LW, 3'b010, 0, 0, 1, 4'd4, mwb);
        // sw with one MEMWRITE wait cycle
        row(1, SW, 3'b010, 0, 0, 1, 4'd0, fet1);
        row(1, SW, 3'b010, 0, 0, 1, 4'd1, dec);
        row(1, SW, 3'b010, 0, 0, 1, 4'd2, madr);
        row(1, SW, 3'b010, 0, 0, 0, 4'd5, mwr);
        row(1, SW, 3'b010, 0, 0, 1, 4'd5, mwr);
        // beq taken, then not taken, then back in FETCH
        row(1, BR, 3'b000, 0, 0, 1, 4'd0, fet1);
        row(1, BR, 3'b000, 0, 0, 1, 4'd1, dec);
        row(1, BR, 3'b000, 0, 1, 1, 4'd9, beq1);
        row(1, BR, 3'b000, 0, 1, 1, 4'd0, fet1);
        row(1, BR, 3'b000, 0, 1, 1, 4'd1, dec);
        row(1, BR, 3'b000, 0, 0, 1, 4'd9, beq0);
        row(1, RT, 3'b000, 0, 0, 1, 4'd0, fet1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].opc, tbl[i].f3, tbl[i].f75,
                  tbl[i].zero, tbl[i].rdy);
            chk_both($sformatf("row%0d", i), tbl[i].st, tbl[i].ctl);
            $display("row %0d: state h=%0d n=%0d ctl h=%05h n=%05h",
                     i, ifh.state, ifn.state, ctl_h, ctl_n);
            @(negedge clk);
        end

        // Illegal encodings: both reach ILLEGAL; halt copy stays there,
        // the other returns to FETCH after one cycle.
        bad_opc[0] = RT;  bad_f3[0] = 3'b001; bad_f75[0] = 1'b0;
        bad_opc[1] = RT;  bad_f3[1] = 3'b110; bad_f75[1] = 1'b1;
        bad_opc[2] = IT;  bad_f3[2] = 3'b010; bad_f75[2] = 1'b0;
        bad_opc[3] = BR;  bad_f3[3] = 3'b001; bad_f75[3] = 1'b0;
        bad_opc[4] = BAD; bad_f3[4] = 3'b000; bad_f75[4] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(0, bad_opc[k], bad_f3[k], bad_f75[k], 0, 1);
            chk_both($sformatf("ill%0d_rst", k), 4'd0, 17'd0);
            @(negedge clk);
            drive(1, bad_opc[k], bad_f3[k], bad_f75[k], 0, 1);
            chk_both($sformatf("ill%0d_fetch", k), 4'd0, fet1);
            @(negedge clk);
            drive(1, bad_opc[k], bad_f3[k], bad_f75[k], 0, 1);
            chk_both($sformatf("ill%0d_decode", k), 4'd1, dec);
            @(negedge clk);
            drive(1, bad_opc[k], bad_f3[k], bad_f75[k], 0, 1);
            chk_both($sformatf("ill%0d_enter", k), 4'd15, ill);
            @(negedge clk);
            drive(1, bad_opc[k], bad_f3[k], bad_f75[k], 0, 1);
            chk($sformatf("ill%0d_hold1", k), ifh.state, 4'd15, ctl_h, ill);
            chk($sformatf("ill%0d_refetch", k), ifn.state, 4'd0, ctl_n, fet1);
            @(negedge clk);
            drive(1, bad_opc[k], bad_f3[k], bad_f75[k], 0, 1);
            chk($sformatf("ill%0d_hold2", k), ifh.state, 4'd15, ctl_h, ill);
            chk($sformatf("ill%0d_redecode", k), ifn.state, 4'd1, ctl_n, dec);
            $display("illegal %0d: state h=%0d n=%0d", k, ifh.state, ifn.state);
            @(negedge clk);
        end

        // Reset during a stalled store: mem_write drops in the same cycle.
        drive(0, SW, 3'b010, 0, 0, 1);
        chk_both("sw_rst_pre", 4'd0, 17'd0);
        @(negedge clk);
        drive(1, SW, 3'b010, 0, 0, 1);
        chk_both("sw_fetch", 4'd0, fet1);
        @(negedge clk);
        drive(1, SW, 3'b010, 0, 0, 1);
        chk_both("sw_decode", 4'd1, dec);
        @(negedge clk);
        drive(1, SW, 3'b010, 0, 0, 1);
        chk_both("sw_memadr", 4'd2, madr);
        @(negedge clk);
        drive(1, SW, 3'b010, 0, 0, 0);
        chk_both("sw_stall", 4'd5, mwr);
        @(negedge clk);
        drive(0, SW, 3'b010, 0, 0, 0);
        chk_both("sw_reset_drop", 4'd0, 17'd0);
        @(negedge clk);
        drive(1, SW, 3'b010, 0, 0, 1);
        chk_both("sw_after_reset", 4'd0, fet1);
        $display("reset during store: state h=%0d n=%0d", ifh.state, ifn.state);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
